// File: rtl/rv32imf_pkg.sv
// Shared types for the rv32imf memory arbiter slice.
//   mem_src_e   : identifies which core requester owns a memory transaction.
//   arb_state_e : arbitration state (open for a fresh pick, or locked onto
//                 a winner whose request has not yet been granted).
//   BE_WORD     : byte-enable value presented for instruction fetches.
package rv32imf_pkg;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } mem_src_e;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/rv32imf_mem_arbiter_if.sv
// Bundle of the three OBI-style ports around the arbiter: core fetch
// requester (instr_*), core load/store requester (data_*), the shared memory
// port (mem_*) and the sticky error flag.
//   slave  : view of the arbiter itself.
//   master : view of the environment (core + memory) driving the arbiter.
interface rv32imf_mem_arbiter_if;
  logic        instr_req_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_addr_i;
  logic [31:0] instr_rdata_o;

  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;

  logic        mem_req_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  logic        err_o;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output err_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  err_o
  );
endinterface

// File: rtl/rv32imf_id_fifo.sv
// Outstanding-transaction ID FIFO: remembers which requester owns each
// granted transaction so responses can be routed in order.
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i/push_id_i : enqueue an ID (ignored when full)
//   pop_i        : dequeue the head (ignored when empty); head_o is the
//                  pre-push head, so push+pop in one cycle is safe
//   full_o/empty_o : occupancy flags
module rv32imf_id_fifo
  import rv32imf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  mem_src_e push_id_i,
  input  logic     pop_i,
  output mem_src_e head_o,
  output logic     full_o,
  output logic     empty_o
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_src_e             id_mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 push_ok;
  logic                 pop_ok;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = id_mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) id_mem[wr_ptr] <= push_id_i;
  end
endmodule

// File: rtl/rv32imf_mem_arbiter.sv
// Two-requester memory arbiter: multiplexes core fetch and load/store
// OBI-style requests onto one memory port, tracks up to MAX_OUTSTANDING
// granted transactions and routes in-order responses back to their owner.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : instr_*, data_*, mem_* handshakes and err_o (slave view)
// Ties alternate (the requester not granted last wins); an ungranted request
// locks the arbiter onto its winner until memory grants it.
module rv32imf_mem_arbiter
  import rv32imf_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  rv32imf_mem_arbiter_if.slave   bus
);
  arb_state_e state_q, state_d;
  mem_src_e   lock_src_q, lock_src_d;
  mem_src_e   last_src_q, last_src_d;
  logic       err_q, err_d;

  mem_src_e   winner;
  mem_src_e   head_id;
  logic       fifo_full;
  logic       fifo_empty;
  logic       any_req;
  logic       mem_req;
  logic       grant;
  logic       pop;

  rv32imf_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (grant),
    .push_id_i (winner),
    .pop_i     (pop),
    .head_o    (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB_OPEN;
      lock_src_q <= SRC_INSTR;
      last_src_q <= SRC_INSTR;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_src_q <= lock_src_d;
      last_src_q <= last_src_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_src_d = lock_src_q;
    last_src_d = last_src_q;
    err_d      = err_q;
    winner     = SRC_INSTR;

    any_req = bus.instr_req_i | bus.data_req_i;

    if (state_q == ARB_LOCKED) begin
      winner = lock_src_q;
    end else if (bus.instr_req_i && bus.data_req_i) begin
      winner = (last_src_q == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
    end else if (bus.data_req_i) begin
      winner = SRC_DATA;
    end

    // Full is judged on the pre-pop occupancy, so a response arriving in
    // the same cycle never frees a slot for an immediate grant.
    mem_req = any_req & ~fifo_full & ~rst_i;
    grant   = mem_req & bus.mem_gnt_i;
    pop     = bus.mem_rvalid_i & ~fifo_empty & ~rst_i;

    if (grant) begin
      state_d    = ARB_OPEN;
      last_src_d = winner;
    end else if (mem_req) begin
      state_d    = ARB_LOCKED;
      lock_src_d = winner;
    end

    if (bus.mem_rvalid_i && fifo_empty && !rst_i) err_d = 1'b1;
  end

  assign bus.mem_req_o      = mem_req;
  assign bus.mem_addr_o     = (winner == SRC_DATA) ? bus.data_addr_i  : bus.instr_addr_i;
  assign bus.mem_we_o       = (winner == SRC_DATA) ? bus.data_we_i    : 1'b0;
  assign bus.mem_be_o       = (winner == SRC_DATA) ? bus.data_be_i    : BE_WORD;
  assign bus.mem_wdata_o    = (winner == SRC_DATA) ? bus.data_wdata_i : 32'h0;

  assign bus.instr_gnt_o    = grant & (winner == SRC_INSTR);
  assign bus.data_gnt_o     = grant & (winner == SRC_DATA);

  assign bus.instr_rvalid_o = pop & (head_id == SRC_INSTR);
  assign bus.data_rvalid_o  = pop & (head_id == SRC_DATA);
  assign bus.instr_rdata_o  = bus.mem_rdata_i;
  assign bus.data_rdata_o   = bus.mem_rdata_i;

  assign bus.err_o          = err_q;
endmodule

// File: doc/rv32imf_mem_arbiter.md
RV32IMF_MEM_ARBITER -- requirements
Module: rv32imf_mem_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_OUTSTANDING, default 2 (legal 1..8): maximum granted transactions still awaiting rvalid.
REQ-002 The block SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have ports instr_req_i  input  1, instr_gnt_o  output  1, instr_rvalid_o  output  1, instr_addr_i  input  32, instr_rdata_o  output  32; these form the core fetch requester (OBI-style req/gnt/rvalid).
REQ-005 The block SHALL have ports data_req_i  input  1, data_gnt_o  output  1, data_rvalid_o  output  1, data_we_i  input  1, data_be_i  input  4, data_addr_i  input  32, data_wdata_i  input  32, data_rdata_o  output  32; these form the core load/store requester.
REQ-006 The block SHALL have ports mem_req_o  output  1, mem_gnt_i  input  1, mem_rvalid_i  input  1, mem_we_o  output  1, mem_be_o  output  4, mem_addr_o  output  32, mem_wdata_o  output  32, mem_rdata_i  input  32; these form the single shared memory port.
REQ-007 The block SHALL have port err_o  output  1  sticky flag: rvalid received with no outstanding transaction.

Function
REQ-008 Winner selection SHALL be combinational; mem_req_o = (instr_req_i | data_req_i) & !full.
REQ-009 If only one requester is active, that requester SHALL win.
REQ-010 If both are active and the block is unlocked, the requester not granted most recently (last_src register) SHALL win.
REQ-011 mem_addr_o/we/be/wdata SHALL mux from the winner; for instr winner: we=0, be=4'hF, wdata=0.
REQ-012 instr_gnt_o/data_gnt_o SHALL equal mem_gnt_i & mem_req_o & (winner==that source); zero-cycle path, no added latency.
REQ-013 Lock: if mem_req_o=1 and mem_gnt_i=0, the block SHALL register the winner and hold it next cycle regardless of the other requester, until a grant occurs.
REQ-014 On grant, last_src SHALL update to the winner and the winner ID SHALL be pushed into the outstanding-ID FIFO.
REQ-015 On mem_rvalid_i with FIFO non-empty, the block SHALL pop the head ID and assert the matching *_rvalid_o in the same cycle; mem_rdata_i SHALL be broadcast to both *_rdata_o.
REQ-016 Responses SHALL be in order; the block SHALL never reorder.
REQ-017 full = (occupancy==MAX_OUTSTANDING); when full, mem_req_o SHALL be 0 and no grant SHALL occur, even if rvalid pops in the same cycle.
REQ-018 A simultaneous grant and rvalid when not full SHALL push and pop in the same cycle with occupancy unchanged; the pop SHALL use the pre-push head.
REQ-019 On mem_rvalid_i with FIFO empty, both *_rvalid_o SHALL stay 0 and err_o SHALL be set until reset.
REQ-020 Occupancy SHALL be a counter of width $clog2(MAX_OUTSTANDING+1); FIFO pointers SHALL wrap modulo MAX_OUTSTANDING.

Reset
REQ-021 While rst_i=1, the block SHALL empty the FIFO, clear occupancy, clear lock, set last_src=SRC_INSTR (data wins the first tie) and clear err_o.
REQ-022 While rst_i=1, the block SHALL force mem_req_o, gnt outputs and rvalid outputs to 0; rdata outputs SHALL follow mem_rdata_i.
REQ-023 Reset mid-transaction SHALL drop all outstanding IDs; later stray rvalids SHALL set err_o per REQ-019.

Structure
REQ-024 Typedef mem_src_e {SRC_INSTR=1'b0, SRC_DATA=1'b1} SHALL live in rv32imf_pkg.
REQ-025 Outstanding-ID storage SHALL be one sub-module, rv32imf_id_fifo (parameter DEPTH, 1-bit payload, push/pop/full/empty/head).

Verification
REQ-026 The bench SHALL cover: single instr req addr 0x100, gnt same cycle, rvalid 2 cycles later, rdata 0xDEADBEEF -> instr_gnt_o in cycle 0, instr_rvalid_o=1 with 0xDEADBEEF, data_rvalid_o=0.
REQ-027 The bench SHALL cover: both reqs every cycle from reset, gnt always 1, rvalid 1 cycle later -> grants alternate D,I,D,I; rvalids route in the same order.
REQ-028 The bench SHALL cover: instr req with mem_gnt_i=0 for 3 cycles, data_req_i rising in cycle 1 -> mem_addr_o holds instr addr through all 4 cycles, first grant goes to instr.
REQ-029 The bench SHALL cover: MAX_OUTSTANDING=2, 3 back-to-back data stores, no rvalid -> 2 grants, then mem_req_o=0; rvalid -> still no grant that cycle, grant the next cycle.
REQ-030 The bench SHALL cover: rvalid with nothing outstanding -> err_o=1 and held; rst_i pulse -> err_o=0.
REQ-031 The bench SHALL cover: rst_i asserted with 2 transactions outstanding -> occupancy 0 after reset; the next 2 rvalids set err_o and assert no *_rvalid_o.
